// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential multiply/divide ALU: function codes,
// control FSM states and the registered flag bundle.
package seq_alu_pkg;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_OR  = 4'd3;
  localparam logic [3:0] FN_MUL = 4'd4;
  localparam logic [3:0] FN_DIV = 4'd5;
  localparam logic [3:0] FN_SLL = 4'd8;
  localparam logic [3:0] FN_SRL = 4'd9;
  localparam logic [3:0] FN_ROL = 4'd10;
  localparam logic [3:0] FN_ROR = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_e;

  typedef struct packed {
    logic zero;
    logic sign;
    logic overflow;
    logic div_by_zero;
    logic illegal_op;
  } alu_flags_t;

endpackage

// File: rtl/iter_muldiv_core.sv
// Unsigned shift-add multiplier / restoring divider on operand magnitudes.
// The first iteration runs on the start edge, so WIDTH iterations end WIDTH-1 edges later.
module iter_muldiv_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] w_q, w_d, w_src;
  logic [WIDTH-1:0]   m_q, m_d, m_src;
  logic               div_q, div_d, div_src;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     sum, diff;

  assign done = busy_q && (cnt_q == LAST);
  assign lo   = w_q[WIDTH-1:0];
  assign hi   = w_q[2*WIDTH-1:WIDTH];

  always_comb begin
    // NOTE: every variable gets a value before any branch, so no path can infer a latch.
    w_src   = start ? {{WIDTH{1'b0}}, a_mag} : w_q;
    m_src   = start ? b_mag : m_q;
    div_src = start ? is_div : div_q;
    sum     = {1'b0, w_src[2*WIDTH-1:WIDTH]} + (w_src[0] ? {1'b0, m_src} : '0);
    diff    = {1'b0, w_src[2*WIDTH-2:WIDTH-1]} - {1'b0, m_src};
    w_d     = w_q;
    m_d     = m_src;
    div_d   = div_src;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start || busy_q) begin
      // Divide: trial-subtract the shifted partial remainder; keep it only if non-negative.
      if (div_src) begin
        w_d = diff[WIDTH] ? {w_src[2*WIDTH-2:0], 1'b0}
                          : {diff[WIDTH-1:0], w_src[WIDTH-2:0], 1'b1};
      end else begin
        w_d = {sum, w_src[WIDTH-1:1]};
      end
      busy_d = !done;
      cnt_d  = done ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the working registers are
  // reset along with the control bits so no X ever reaches the sign-fix stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q    <= '0;
      m_q    <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      w_q    <= w_d;
      m_q    <= m_d;
      div_q  <= div_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_muldiv_alu.sv
// EX-stage ALU: single-cycle add/sub/logic/shift/rotate, iterative signed mul/div,
// valid/ready on both sides and a registered result/flag stage.
module seq_muldiv_alu
  import seq_alu_pkg::*;
#(
  parameter  int WIDTH   = 16,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         func,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   res_lo,
  output logic [WIDTH-1:0]   res_hi,
  output logic               zero,
  output logic               sign,
  output logic               overflow,
  output logic               div_by_zero,
  output logic               illegal_op
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  logic               accept, is_iter, div_special, core_start, core_done;
  logic               load_single, load_fix;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d, div_op_q, div_op_d;
  logic [WIDTH-1:0]   core_lo, core_hi;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  alu_flags_t         flags_q, flags_d, sc_flags, fx_flags;
  logic [WIDTH-1:0]   sc_lo, sc_hi, fx_lo, fx_hi, add_r, sub_r;
  logic [2*WIDTH-1:0] rol_w, ror_w, prod_mag;

  assign div_special = (b == '0) || (a == MIN_VAL && b == '1);
  assign is_iter     = (func == FN_MUL) || (func == FN_DIV && !div_special);

  // FSM output process: handshake and load strobes.
  always_comb begin
    in_ready    = rst_n && (state_q == IDLE) && (!out_valid_q || out_ready) && !flush;
    accept      = in_valid && in_ready;
    core_start  = accept && is_iter;
    load_single = accept && !is_iter;
    load_fix    = (state_q == FIX) && !flush;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (core_start) state_d = (func == FN_MUL) ? MUL : DIV;
        MUL, DIV: if (core_done) state_d = FIX;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  iter_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .abort (flush),
    .start (core_start),
    .is_div(func == FN_DIV),
    .a_mag (a[MSB] ? -a : a),
    .b_mag (b[MSB] ? -b : b),
    .done  (core_done),
    .lo    (core_lo),
    .hi    (core_hi)
  );

  always_comb begin
    add_r    = a + b;
    sub_r    = a - b;
    rol_w    = {a, a} << shamt;
    ror_w    = {a, a} >> shamt;
    sc_lo    = '0;
    sc_hi    = '0;
    sc_flags = '0;
    case (func)
      FN_ADD: begin
        sc_lo             = add_r;
        sc_flags.overflow = (a[MSB] == b[MSB]) && (add_r[MSB] != a[MSB]);
      end
      FN_SUB: begin
        sc_lo             = sub_r;
        sc_flags.overflow = (a[MSB] != b[MSB]) && (sub_r[MSB] != a[MSB]);
      end
      FN_AND: sc_lo = a & b;
      FN_OR:  sc_lo = a | b;
      FN_SLL: sc_lo = a << shamt;
      FN_SRL: sc_lo = a >> shamt;
      FN_ROL: sc_lo = rol_w[2*WIDTH-1:WIDTH];
      FN_ROR: sc_lo = ror_w[WIDTH-1:0];
      FN_MUL: ;
      FN_DIV: begin
        if (b == '0) begin
          sc_flags.div_by_zero = 1'b1;
          sc_hi                = a;
        end else if (div_special) begin
          sc_lo             = MIN_VAL;
          sc_flags.overflow = 1'b1;
        end
      end
      default: sc_flags.illegal_op = 1'b1;
    endcase
    sc_flags.zero = (sc_lo == '0);
    sc_flags.sign = sc_lo[MSB];
  end

  // Sign fix: quotient negative when signs differ, remainder follows the dividend.
  always_comb begin
    prod_mag = {core_hi, core_lo};
    fx_lo    = '0;
    fx_hi    = '0;
    fx_flags = '0;
    if (div_op_q) begin
      fx_lo = (neg_a_q ^ neg_b_q) ? -core_lo : core_lo;
      fx_hi = neg_a_q ? -core_hi : core_hi;
    end else begin
      {fx_hi, fx_lo} = (neg_a_q ^ neg_b_q) ? -prod_mag : prod_mag;
    end
    fx_flags.zero = (fx_lo == '0);
    fx_flags.sign = fx_lo[MSB];
  end

  always_comb begin
    neg_a_d     = core_start ? a[MSB] : neg_a_q;
    neg_b_d     = core_start ? b[MSB] : neg_b_q;
    div_op_d    = core_start ? (func == FN_DIV) : div_op_q;
    out_valid_d = out_valid_q;
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    flags_d     = flags_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load_single) begin
      out_valid_d = 1'b1;
      res_lo_d    = sc_lo;
      res_hi_d    = sc_hi;
      flags_d     = sc_flags;
    end else if (load_fix) begin
      out_valid_d = 1'b1;
      res_lo_d    = fx_lo;
      res_hi_d    = fx_hi;
      flags_d     = fx_flags;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      div_op_q    <= 1'b0;
      out_valid_q <= 1'b0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      flags_q     <= '0;
    end else begin
      neg_a_q     <= neg_a_d;
      neg_b_q     <= neg_b_d;
      div_op_q    <= div_op_d;
      out_valid_q <= out_valid_d;
      res_lo_q    <= res_lo_d;
      res_hi_q    <= res_hi_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign res_lo      = res_lo_q;
  assign res_hi      = res_hi_q;
  assign zero        = flags_q.zero;
  assign sign        = flags_q.sign;
  assign overflow    = flags_q.overflow;
  assign div_by_zero = flags_q.div_by_zero;
  assign illegal_op  = flags_q.illegal_op;

endmodule

// File: tb/tb_seq_muldiv_alu.sv
// Directed bench for seq_muldiv_alu at WIDTH=16 plus a WIDTH=32 instance checked
// against a behavioural reference for MUL/DIV/ROL.
module tb_seq_muldiv_alu;
  import seq_alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        flush16, iv16, ir16, ov16, or16, z16, s16, o16, d16, il16;
  logic [3:0]  f16, sh16;
  logic [15:0] a16, b16, lo16, hi16;
  logic [4:0]  fl16;
  assign fl16 = {z16, s16, o16, d16, il16};

  logic        flush32, iv32, ir32, ov32, or32, z32, s32, o32, d32, il32;
  logic [3:0]  f32;
  logic [4:0]  sh32;
  logic [31:0] a32, b32, lo32, hi32;

  seq_muldiv_alu #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush16), .in_valid(iv16), .in_ready(ir16),
    .func(f16), .a(a16), .b(b16), .shamt(sh16), .out_valid(ov16), .out_ready(or16),
    .res_lo(lo16), .res_hi(hi16), .zero(z16), .sign(s16), .overflow(o16),
    .div_by_zero(d16), .illegal_op(il16)
  );

  seq_muldiv_alu #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush32), .in_valid(iv32), .in_ready(ir32),
    .func(f32), .a(a32), .b(b32), .shamt(sh32), .out_valid(ov32), .out_ready(or32),
    .res_lo(lo32), .res_hi(hi32), .zero(z32), .sign(s32), .overflow(o32),
    .div_by_zero(d32), .illegal_op(il32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns with the result visible, lat counted
  // in edges from the accept edge (inclusive) to the edge that raised out_valid.
  task automatic issue16(input logic [3:0] f, input logic [15:0] av, input logic [15:0] bv,
                         input logic [3:0] sh, output int lat, output logic ir_ok);
    int w = 0;
    f16 = f; a16 = av; b16 = bv; sh16 = sh; iv16 = 1'b1;
    #1;
    while (!ir16 && w < 50) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    iv16 = 1'b0;
    lat = 1; ir_ok = 1'b1;
    while (!ov16 && lat < 100) begin
      if (ir16) ir_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic issue32(input logic [3:0] f, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] sh, output int lat);
    int w = 0;
    f32 = f; a32 = av; b32 = bv; sh32 = sh; iv32 = 1'b1;
    #1;
    while (!ir32 && w < 50) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    iv32 = 1'b0;
    lat = 1;
    while (!ov32 && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic vec16(input string tag, input logic [3:0] f, input logic [15:0] av,
                       input logic [15:0] bv, input logic [3:0] sh, input logic [15:0] exp_lo,
                       input logic [15:0] exp_hi, input logic [4:0] exp_fl, input int exp_lat);
    int lat;
    logic ir_ok;
    issue16(f, av, bv, sh, lat, ir_ok);
    check({tag, "_lo"}, lo16, exp_lo);
    check({tag, "_hi"}, hi16, exp_hi);
    check({tag, "_flags"}, fl16, exp_fl);
    check({tag, "_lat"}, lat, exp_lat);
    if (exp_lat > 1) check({tag, "_busy_ready"}, ir_ok, 1'b1);
  endtask

  task automatic no_stale16(input string tag);
    int seen = 0;
    repeat (20) begin @(posedge clk); #1; if (ov16) seen++; end
    check(tag, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    logic stable;
    logic [31:0] ra, rb, rexp, qexp, rmexp;
    longint prod;
    int qa, qb;

    rst_n = 1'b1;
    {flush16, iv16, f16, sh16, a16, b16} = '0;
    {flush32, iv32, f32, sh32, a32, b32} = '0;
    or16 = 1'b1; or32 = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", ov16, 1'b0);
    check("rst_in_ready", ir16, 1'b0);
    check("rst_result", {hi16, lo16}, 32'h0);
    check("rst_flags", fl16, 5'b0);
    rst_n = 1'b1;
    #1 check("rst_release_ready", ir16, 1'b1);
    @(posedge clk); #1;

    // flags are {zero, sign, overflow, div_by_zero, illegal_op}
    vec16("add_ovf",  FN_ADD, 16'h7FFF, 16'h0001, 4'd0,  16'h8000, 16'h0000, 5'b01100, 1);
    vec16("sub_ovf",  FN_SUB, 16'h8000, 16'h0001, 4'd0,  16'h7FFF, 16'h0000, 5'b00100, 1);
    vec16("sub_zero", FN_SUB, 16'h0005, 16'h0005, 4'd0,  16'h0000, 16'h0000, 5'b10000, 1);
    vec16("and",      FN_AND, 16'hF0F0, 16'h3C3C, 4'd0,  16'h3030, 16'h0000, 5'b00000, 1);
    vec16("or",       FN_OR,  16'hF0F0, 16'h0F0F, 4'd0,  16'hFFFF, 16'h0000, 5'b01000, 1);
    vec16("mul_neg",  FN_MUL, 16'hFFFD, 16'h0007, 4'd0,  16'hFFEB, 16'hFFFF, 5'b01000, 17);
    vec16("mul_min",  FN_MUL, 16'h8000, 16'h8000, 4'd0,  16'h0000, 16'h4000, 5'b10000, 17);
    vec16("div_neg",  FN_DIV, 16'hFFF9, 16'h0002, 4'd0,  16'hFFFD, 16'hFFFF, 5'b01000, 17);
    vec16("div_negb", FN_DIV, 16'h0007, 16'hFFFE, 4'd0,  16'hFFFD, 16'h0001, 5'b01000, 17);
    vec16("div_zero", FN_DIV, 16'h0005, 16'h0000, 4'd0,  16'h0000, 16'h0005, 5'b10010, 1);
    vec16("div_ovf",  FN_DIV, 16'h8000, 16'hFFFF, 4'd0,  16'h8000, 16'h0000, 5'b01100, 1);
    vec16("rol",      FN_ROL, 16'h8001, 16'h0000, 4'd1,  16'h0003, 16'h0000, 5'b00000, 1);
    vec16("ror",      FN_ROR, 16'h1234, 16'h0000, 4'd4,  16'h4123, 16'h0000, 5'b00000, 1);
    vec16("rol_zero", FN_ROL, 16'hABCD, 16'h0000, 4'd0,  16'hABCD, 16'h0000, 5'b01000, 1);
    vec16("srl",      FN_SRL, 16'h8000, 16'h0000, 4'd15, 16'h0001, 16'h0000, 5'b00000, 1);
    vec16("sll",      FN_SLL, 16'h0001, 16'h0000, 4'd15, 16'h8000, 16'h0000, 5'b01000, 1);
    vec16("illegal6", 4'd6,   16'h1234, 16'h0001, 4'd0,  16'h0000, 16'h0000, 5'b10001, 1);
    vec16("illegal15",4'd15,  16'hFFFF, 16'hFFFF, 4'd3,  16'h0000, 16'h0000, 5'b10001, 1);

    // Backpressure: hold an ADD result while a SUB waits, then retire both.
    @(posedge clk); #1;
    or16 = 1'b0;
    f16 = FN_ADD; a16 = 16'd3; b16 = 16'd4; sh16 = '0; iv16 = 1'b1;
    #1 check("bp_accept_ready", ir16, 1'b1);
    @(posedge clk); #1;
    f16 = FN_SUB; a16 = 16'd9; b16 = 16'd1;
    check("bp_add_valid", ov16, 1'b1);
    check("bp_add_lo", lo16, 16'h0007);
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!ov16 || lo16 !== 16'h0007 || hi16 !== 16'h0 || fl16 !== 5'b0 || ir16) stable = 1'b0;
    end
    check("bp_hold_stable", stable, 1'b1);
    or16 = 1'b1;
    #1 check("bp_release_ready", ir16, 1'b1);
    @(posedge clk); #1;
    iv16 = 1'b0;
    check("bp_sub_valid", ov16, 1'b1);
    check("bp_sub_lo", lo16, 16'h0008);
    @(posedge clk); #1;
    check("bp_drain", ov16, 1'b0);

    // Async reset eight cycles into a DIV.
    f16 = FN_DIV; a16 = 16'd100; b16 = 16'd3; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    repeat (8) @(posedge clk);
    #1 check("rstdiv_busy_ready", ir16, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rstdiv_out_valid", ov16, 1'b0);
    check("rstdiv_result", {hi16, lo16}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 check("rstdiv_ready", ir16, 1'b1);
    vec16("rst_add", FN_ADD, 16'd2, 16'd2, 4'd0, 16'h0004, 16'h0000, 5'b00000, 1);
    no_stale16("rstdiv_no_stale");

    // Synchronous flush eight cycles into a DIV.
    f16 = FN_DIV; a16 = 16'd100; b16 = 16'd3; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    flush16 = 1'b1;
    #1 check("flush_ready_low", ir16, 1'b0);
    @(posedge clk); #1;
    flush16 = 1'b0;
    #1;
    check("flush_out_valid", ov16, 1'b0);
    check("flush_ready", ir16, 1'b1);
    vec16("flush_add", FN_ADD, 16'd2, 16'd2, 4'd0, 16'h0004, 16'h0000, 5'b00000, 1);
    no_stale16("flush_no_stale");

    // WIDTH=32 against a behavioural reference.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom;
      if (i == 0) rb = 32'hFFFF_FFFF;
      prod = longint'($signed(ra)) * longint'($signed(rb));
      issue32(FN_MUL, ra, rb, 5'd0, lat);
      check("mul32", {hi32, lo32}, prod);
      check("mul32_lat", lat, 33);
    end
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rb = -rb;
      if (rb == 32'h0) rb = 32'd7;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      qa = int'(ra); qb = int'(rb);
      qexp = qa / qb;
      rmexp = qa % qb;
      issue32(FN_DIV, ra, rb, 5'd0, lat);
      check("div32_q", lo32, qexp);
      check("div32_r", hi32, rmexp);
      check("div32_lat", lat, 33);
    end
    for (int i = 0; i < 8; i++) begin
      logic [4:0] sh;
      ra = $urandom;
      sh = (i == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rexp = ra;
      for (int k = 0; k < int'(sh); k++) rexp = {rexp[30:0], rexp[31]};
      issue32(FN_ROL, ra, 32'h0, sh, lat);
      check("rol32", lo32, rexp);
      check("rol32_lat", lat, 1);
    end

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
